// File: rtl/seg7_bin2bcd.sv
// Binary-to-packed-BCD converter (serial double-dabble) feeding the 4-digit seven-segment driver.
// Optional feature: define SEG7_LZ_BLANK_EN for leading-zero blanking on sel.
module seg7_bin2bcd #(
    parameter int IN_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [15:0]     num,
    output logic [3:0]      sel,
    output logic            ovf,
    output logic            done
);

    localparam int CNT_W = $clog2(IN_W + 1);

`ifdef SEG7_LZ_BLANK_EN
    localparam logic [3:0] SEL_RST = 4'b0001;
`else
    localparam logic [3:0] SEL_RST = 4'b1111;
`endif

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        OUT
    } state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   shift_q;
    logic [15:0]       bcd_q;
    logic [15:0]       bcd_adj;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_pend_q;
    logic              ovf_in;
    logic              accept;
    logic [3:0]        sel_calc;

    assign in_ready = (state_q == IDLE) & ~rst;

    // Only inputs wider than 13 bits can exceed 9999.
    generate
        if (IN_W > 13) begin : g_ovf
            assign ovf_in = (32'(in_data) > 32'd9999);
        end else begin : g_no_ovf
            assign ovf_in = 1'b0;
        end
    endgenerate

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV:    if (cnt_q == CNT_W'(1)) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Add-3 correction on every nibble that would overflow a decimal digit after the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    always_comb begin
        sel_calc    = 4'b0001;
        sel_calc[3] = |bcd_q[15:12];
        sel_calc[2] = sel_calc[3] | (|bcd_q[11:8]);
        sel_calc[1] = sel_calc[2] | (|bcd_q[7:4]);
    end
`else
    assign sel_calc = 4'b1111;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            num        <= 16'h0000;
            sel        <= SEL_RST;
            ovf        <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= (state_q == OUT);
            if (accept) begin
                shift_q    <= in_data;
                bcd_q      <= '0;
                cnt_q      <= CNT_W'(IN_W);
                ovf_pend_q <= ovf_in;
            end
            if (state_q == CONV) begin
                // Carry out of the top BCD bit falls off the left end; ovf covers those values.
                {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
                cnt_q            <= cnt_q - CNT_W'(1);
            end
            if (state_q == OUT) begin
                ovf <= ovf_pend_q;
                num <= ovf_pend_q ? 16'hEEEE : bcd_q;
                sel <= ovf_pend_q ? 4'b1111 : sel_calc;
            end
        end
    end

endmodule

// File: tb/tb_seg7_bin2bcd.sv
// Directed self-checking bench for seg7_bin2bcd (IN_W = 16); follows SEG7_LZ_BLANK_EN if defined.
module tb_seg7_bin2bcd;

`ifdef SEG7_LZ_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] num;
    logic [3:0]  sel;
    logic        ovf;
    logic        done;

    int checks = 0;
    int errors = 0;

    seg7_bin2bcd #(.IN_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .num      (num),
        .sel      (sel),
        .ovf      (ovf),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one value; lat = edges from accept to done (-1 on timeout), mid = num 8 edges in.
    task automatic send(input logic [15:0] v, output int lat, output logic [15:0] mid);
        lat = -1;
        mid = 'x;
        in_data  = v;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !in_ready; i++) step();
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        step();
        in_valid = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            step();
            if (n == 8) mid = num;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready_low: got %b want 0", in_ready);
            end
        end
        rst = 1'b0;
        step();
        checks++;
        if (num !== 16'h0000 || sel !== (BLANK ? 4'b0001 : 4'b1111) || ovf !== 1'b0 ||
            done !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got num=%h sel=%b ovf=%b done=%b rdy=%b", num, sel, ovf, done, in_ready);
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [15:0] mid;
        send(16'd1234, lat, mid);
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 17", lat);
        end
        checks++;
        if (mid !== 16'h0000) begin
            errors++;
            $display("FAIL basic_num_stable: got %h want 0000", mid);
        end
        checks++;
        if (num !== 16'h1234 || sel !== 4'b1111 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_1234: got num=%h sel=%b ovf=%b want 1234 1111 0", num, sel, ovf);
        end
        step();
        checks++;
        if (done !== 1'b0 || num !== 16'h1234) begin
            errors++;
            $display("FAIL basic_done_pulse: got done=%b num=%h want 0 1234", done, num);
        end
    endtask

    task automatic test_blank();
        int lat;
        logic [15:0] mid;
        send(16'd7, lat, mid);
        checks++;
        if (lat !== 17 || num !== 16'h0007 || sel !== (BLANK ? 4'b0001 : 4'b1111)) begin
            errors++;
            $display("FAIL blank_7: got lat=%0d num=%h sel=%b", lat, num, sel);
        end
        send(16'd305, lat, mid);
        checks++;
        if (mid !== 16'h0007) begin
            errors++;
            $display("FAIL blank_num_stable: got %h want 0007", mid);
        end
        checks++;
        if (lat !== 17 || num !== 16'h0305 || sel !== (BLANK ? 4'b0111 : 4'b1111)) begin
            errors++;
            $display("FAIL blank_305: got lat=%0d num=%h sel=%b", lat, num, sel);
        end
    endtask

    task automatic test_back_to_back();
        int lows;
        in_data  = 16'd42;
        in_valid = 1'b1;
        step();
        lows = 0;
        while (!in_ready && lows < 100) begin
            lows++;
            step();
        end
        checks++;
        if (lows !== 17 || done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_busy: got lows=%0d done=%b want 17 1", lows, done);
        end
        checks++;
        if (num !== 16'h0042 || sel !== (BLANK ? 4'b0011 : 4'b1111) || ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_42: got num=%h sel=%b ovf=%b", num, sel, ovf);
        end
        in_data = 16'd0;
        step();
        checks++;
        if (in_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_accept: got rdy=%b done=%b want 0 0", in_ready, done);
        end
        lows = 0;
        while (!in_ready && lows < 100) begin
            lows++;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (lows !== 17 || done !== 1'b1 || num !== 16'h0000 || sel !== (BLANK ? 4'b0001 : 4'b1111)) begin
            errors++;
            $display("FAIL b2b_0: got lows=%0d done=%b num=%h sel=%b", lows, done, num, sel);
        end
        step();
    endtask

    task automatic test_ovf();
        int lat;
        logic [15:0] mid;
        send(16'd9999, lat, mid);
        checks++;
        if (lat !== 17 || num !== 16'h9999 || sel !== 4'b1111 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_9999: got lat=%0d num=%h sel=%b ovf=%b", lat, num, sel, ovf);
        end
        send(16'd10000, lat, mid);
        checks++;
        if (mid !== 16'h9999) begin
            errors++;
            $display("FAIL ovf_num_stable: got %h want 9999", mid);
        end
        checks++;
        if (lat !== 17 || num !== 16'hEEEE || sel !== 4'b1111 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_10000: got lat=%0d num=%h sel=%b ovf=%b", lat, num, sel, ovf);
        end
        send(16'd65535, lat, mid);
        checks++;
        if (lat !== 17 || num !== 16'hEEEE || sel !== 4'b1111 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_65535: got lat=%0d num=%h sel=%b ovf=%b", lat, num, sel, ovf);
        end
    endtask

    task automatic test_abort();
        in_data  = 16'd4321;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b0 || num !== 16'h0000 || sel !== (BLANK ? 4'b0001 : 4'b1111) ||
            ovf !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset_vals: got rdy=%b num=%h sel=%b ovf=%b done=%b", in_ready, num, sel, ovf, done);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready: got %b want 1", in_ready);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (done !== 1'b0 || num !== 16'h0000) begin
                errors++;
                $display("FAIL abort_no_done: cycle %0d got done=%b num=%h", i, done, num);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blank();
        test_back_to_back();
        test_ovf();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
